wlm_fold: RTL
=============

// Module: wlm_fold
// PURPOSE
//  Folded, handshaked word-level Montgomery reducer for NTT-friendly moduli q = qH*2^R + 1.
//  It performs the same R-bit word reduction as the unrolled pipeline, reusing one word-reduction datapath over ITER cycles.
//  It targets area-constrained modmul instances where throughput of 1 result per ITER+2 cycles suffices.
//  qH is latched per operation, so consecutive operations may use different moduli.
// PARAMETERS
//  LOGQ  60  modulus width in bits; q < 2^LOGQ
//  R     17  word size, i.e. bits retired per reduction step; 1 <= R < LOGQ
//  K     2*LOGQ  (localparam) input operand width
//  LOGQH LOGQ-R  (localparam) width of qH
//  ITER  ceil(LOGQ/R)  (localparam) number of reduction steps
// PORTS
//  clk        in   1        rising-edge clock
//  rst        in   1        asynchronous reset, active-low (0 = reset)
//  in_valid   in   1        operand valid
//  in_ready   out  1        reducer can accept operand
//  qH         in   LOGQH    modulus high part, sampled with C
//  C          in   K        operand; caller guarantees C < q*2^LOGQ
//  out_valid  out  1        result valid
//  out_ready  in   1        consumer accepts result
//  T          out  LOGQ+1   result, congruent to C*2^(-R*ITER) mod q
// BEHAVIOUR
//  Reset (rst=0, async): state=IDLE, in_ready=0 while rst=0, then 1; out_valid=0; T=0; step counter=0; acc=0; qH_r=0.
//  FSM: IDLE -> RUN on in_valid&in_ready; RUN -> (SUB if macro, else DONE) after ITER steps;
//   SUB -> DONE after 1 cycle; DONE -> IDLE on out_ready.
//  in_ready=1 only in IDLE (out of reset). out_valid=1 only in DONE. T is held stable while out_valid&!out_ready.
//  Accept edge: acc<=C, qH_r<=qH, cnt<=0. C and qH are don't-care when not accepted.
//  Per RUN cycle: c0=acc[R-1:0]; m=(2^R-c0) mod 2^R; acc<=(acc>>R)+qH_r*m+(c0!=0); cnt<=cnt+1.
//   The product is LOGQH x R bits, and the sum is computed at K bits with no truncation loss given the C bound.
//  After ITER steps: acc < 2q. T<=acc[LOGQ:0] entering DONE (or SUB).
//  Latency: out_valid rises ITER+1 cycles after the accept edge (ITER+2 with the macro).
//   Earliest next accept is 1 cycle after the out handshake.
//  out_ready ignored outside DONE; in_valid ignored outside IDLE (no buffering, no drop of the held result).
//  The out handshake and in_valid in the same cycle: the new operand is NOT accepted that cycle (in_ready=0 in DONE).
//  c0==0: m=0, no +1 carry (exact shift). qH=0: degenerate q=1 and is legal; the result is 0 or 1, or 0 with the macro.
//  Mid-operation reset: acc, cnt and the FSM are cleared immediately. No out_valid for the aborted operand.
// CONFIGURATION
//  WLM_FOLD_FINAL_SUB_EN defined:
//   Adds the SUB state. q=(qH_r<<R)+1; T<=(acc>=q)?acc-q:acc, so T < q and T[LOGQ]=0.
//  Undefined:
//   No SUB state. T=acc in [0,2q), T[LOGQ] may be 1. Latency is reduced by 1 cycle.
// TESTING  (LOGQ=8, R=4 -> ITER=2, qH=6, q=97, 2^-8 mod 97 = 36, unless noted)
//  Reset: hold rst=0 with random inputs -> out_valid=0, T=0, in_ready=0. Release -> in_ready=1 next cycle.
//  C=1 -> T=36, with or without the macro.
//   Intermediates: acc=91 after step 1, 36 after step 2.
//   out_valid at accept+3 (macro off) or accept+4 (macro on).
//  C=97 -> raw acc=97.
//   Macro on: T=0.
//   Macro off: T=97.
//  C=9216 (96*96) -> T=36. C=0 -> T=0.
//  Stall: C=1, out_ready=0 for 10 cycles -> out_valid and T=36 held, in_ready=0, in_valid pulses ignored.
//   After out_ready=1 -> IDLE next cycle.
//  Reset mid-RUN: assert rst=0 at accept+1 -> FSM IDLE, no out_valid.
//   A following C=1 -> T=36.
//  Default params (LOGQ=60, R=17, ITER=4): 1000 random qH and C < q*2^60, checked against a reference model.
//   Check: T ≡ C*2^-68 mod q, with T<2q (macro off) or T<q (macro on).

Source files
------------

// File: rtl/wlm_fold_if.sv
`default_nettype none
// ============================================================================
// Module      : wlm_fold_if
// Description : Operand/result handshake bundle for the folded word-level
//               Montgomery reducer.
// Revision    : 1.0 - initial release
// ============================================================================
interface wlm_fold_if #(
    parameter int LOGQ = 60,
    parameter int R    = 17
);
    localparam int K     = 2 * LOGQ;
    localparam int LOGQH = LOGQ - R;

    logic             in_valid;
    logic             in_ready;
    logic [LOGQH-1:0] qH;
    logic [K-1:0]     C;
    logic             out_valid;
    logic             out_ready;
    logic [LOGQ:0]    T;

    modport master (
        output in_valid, qH, C, out_ready,
        input  in_ready, out_valid, T
    );

    modport slave (
        input  in_valid, qH, C, out_ready,
        output in_ready, out_valid, T
    );
endinterface
`default_nettype wire

// File: rtl/wlm_fold.sv
`default_nettype none
// ============================================================================
// Module      : wlm_fold
// Description : Folded word-level Montgomery reducer for q = qH*2^R + 1.
//               One R-bit reduction step per cycle over ITER cycles.
//               Optional final conditional subtraction: WLM_FOLD_FINAL_SUB_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module wlm_fold #(
    parameter int LOGQ = 60,
    parameter int R    = 17
) (
    input  wire logic clk,
    input  wire logic rst,
    wlm_fold_if.slave bus
);
    localparam int K     = 2 * LOGQ;
    localparam int LOGQH = LOGQ - R;
    localparam int ITER  = (LOGQ + R - 1) / R;
    localparam int CNT_W = $clog2(ITER + 1);

    localparam logic [CNT_W-1:0] c_CNT_LAST = CNT_W'(ITER);
    localparam logic [CNT_W-1:0] c_CNT_ONE  = CNT_W'(1);
    localparam logic [R-1:0]     c_ONE_R    = R'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_SUB  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [K-1:0]     r_acc;
    logic [LOGQH-1:0] r_qh;
    logic [LOGQ:0]    r_t;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [R-1:0]     w_c0;
    logic             w_c0_nz;
    logic [R-1:0]     w_m;
    logic [LOGQ-1:0]  w_prod;
    logic [K-1:0]     w_acc_next;

    // m = -c0 mod 2^R makes acc + q*m divisible by 2^R; since q = qH*2^R + 1
    // the low word c0 + m is exactly 2^R whenever c0 != 0, hence the +1.
    assign w_c0       = r_acc[R-1:0];
    assign w_c0_nz    = |w_c0;
    assign w_m        = (~w_c0) + c_ONE_R;
    assign w_prod     = {{R{1'b0}}, r_qh} * {{LOGQH{1'b0}}, w_m};
    assign w_acc_next = (r_acc >> R)
                      + {{(K - LOGQ){1'b0}}, w_prod}
                      + {{(K - 1){1'b0}}, w_c0_nz};

`ifdef WLM_FOLD_FINAL_SUB_EN
    localparam logic [LOGQ:0] c_ONE_Q = (LOGQ + 1)'(1);

    logic [LOGQ:0] w_q;
    logic [LOGQ:0] w_t_red;

    assign w_q     = {1'b0, r_qh, {R{1'b0}}} | c_ONE_Q;
    assign w_t_red = (r_acc[LOGQ:0] >= w_q) ? (r_acc[LOGQ:0] - w_q) : r_acc[LOGQ:0];
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_cnt       <= '0;
            r_acc       <= '0;
            r_qh        <= '0;
            r_t         <= '0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_in_ready  <= 1'b1;
                    r_out_valid <= 1'b0;
                    if (bus.in_valid && r_in_ready) begin
                        r_acc      <= bus.C;
                        r_qh       <= bus.qH;
                        r_cnt      <= '0;
                        r_in_ready <= 1'b0;
                        r_state    <= S_RUN;
                    end
                end

                S_RUN: begin
                    if (r_cnt == c_CNT_LAST) begin
                        r_t <= r_acc[LOGQ:0];
`ifdef WLM_FOLD_FINAL_SUB_EN
                        r_state <= S_SUB;
`else
                        r_state     <= S_DONE;
                        r_out_valid <= 1'b1;
`endif
                    end else begin
                        r_acc <= w_acc_next;
                        r_cnt <= r_cnt + c_CNT_ONE;
                    end
                end

`ifdef WLM_FOLD_FINAL_SUB_EN
                S_SUB: begin
                    r_t         <= w_t_red;
                    r_state     <= S_DONE;
                    r_out_valid <= 1'b1;
                end
`endif

                S_DONE: begin
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end

                default: begin
                    r_in_ready  <= 1'b0;
                    r_out_valid <= 1'b0;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.T         = r_t;

endmodule
`default_nettype wire
